// File: rtl/karnaugh_sweep_checker.sv
// Purpose : sweeps every input combination of an N_IN-input combinational function,
//           captures its truth table and compares it against an expected table.
// Latency : 2**N_IN*(SETTLE+1) cycles from start accept to the DONE cycle (32 for defaults).
// Backpressure: none; start is only honoured in IDLE and ignored while busy or done.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          begin a sweep (accepted only when idle)
//   exp_tt         expected truth table, bit i = f(vec==i); held stable while busy
//   f_in           output of the function under check for the current vec
//   vec            drives the function inputs (vec[N_IN-1]=a ... vec[0]=d)
//   busy / done    sweep in progress / one-cycle end-of-sweep pulse
//   tt             captured truth table
//   err_cnt        number of mismatching entries
//   first_err(_vld) lowest mismatching index and its valid flag
//   pass           no mismatches; valid from done until the next accepted start
module karnaugh_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_tt,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      first_err,
  output logic                 first_err_vld,
  output logic                 pass
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] VEC_MAX  = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NV-1:0]     tt_q, tt_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   ferr_q, ferr_d;
  logic              fvld_q, fvld_d;
  logic              pass_q, pass_d;

  logic              mismatch;
  logic              last_vec;

  assign mismatch = f_in ^ exp_tt[vec_q];
  assign last_vec = (vec_q == VEC_MAX);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    fvld_d  = fvld_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          vec_d   = '0;
          cnt_d   = CNT_INIT;
          tt_d    = '0;
          err_d   = '0;
          ferr_d  = '0;
          fvld_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      // Hold vec for SETTLE cycles so the function output has settled.
      S_APPLY: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_SAMPLE: begin
        tt_d[vec_q] = f_in;
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          // Entries are visited in ascending order, so the first recorded
          // mismatch is also the lowest index.
          if (!fvld_q) begin
            ferr_d = vec_q;
            fvld_d = 1'b1;
          end
        end
        if (last_vec) begin
          state_d = S_DONE;
          // Include this final entry in the verdict.
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = CNT_INIT;
          state_d = S_APPLY;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      fvld_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      fvld_q  <= fvld_d;
      pass_q  <= pass_d;
    end
  end

  // All outputs come straight from registers or state decode, so there is
  // no combinational path from f_in to any output.
  assign vec           = vec_q;
  assign busy          = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done          = (state_q == S_DONE);
  assign tt            = tt_q;
  assign err_cnt       = err_q;
  assign first_err     = ferr_q;
  assign first_err_vld = fvld_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_karnaugh_sweep_checker.sv
// Bench for karnaugh_sweep_checker: two instances (SETTLE=1 and SETTLE=3) share
// reset and expected table; each drives its own model of the function under check.
module tb_karnaugh_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] exp_tt;
  logic [15:0] func_tt;   // truth table of the modelled function under check
  logic        sel;       // 0: observe instance a, 1: instance b

  logic [3:0]  vec_a, vec_b, ferr_a, ferr_b;
  logic        busy_a, busy_b, done_a, done_b, fvld_a, fvld_b, pass_a, pass_b;
  logic [15:0] tt_a, tt_b;
  logic [4:0]  err_a, err_b;
  logic        f_a, f_b;

  assign f_a = func_tt[vec_a];
  assign f_b = func_tt[vec_b];

  karnaugh_sweep_checker #(.N_IN(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .exp_tt(exp_tt), .f_in(f_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .tt(tt_a), .err_cnt(err_a),
    .first_err(ferr_a), .first_err_vld(fvld_a), .pass(pass_a)
  );

  karnaugh_sweep_checker #(.N_IN(4), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .exp_tt(exp_tt), .f_in(f_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .tt(tt_b), .err_cnt(err_b),
    .first_err(ferr_b), .first_err_vld(fvld_b), .pass(pass_b)
  );

  logic [3:0]  o_vec, o_ferr;
  logic        o_busy, o_done, o_fvld, o_pass;
  logic [15:0] o_tt;
  logic [4:0]  o_err;
  assign o_vec  = sel ? vec_b  : vec_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_tt   = sel ? tt_b   : tt_a;
  assign o_err  = sel ? err_b  : err_a;
  assign o_ferr = sel ? ferr_b : ferr_a;
  assign o_fvld = sel ? fvld_b : fvld_a;
  assign o_pass = sel ? pass_b : pass_a;

  int total = 0;
  int bad   = 0;

  // Expected results derived from the two tables: every differing bit is an error.
  task automatic model(input logic [15:0] ft, input logic [15:0] et,
                       output logic [15:0] e_tt, output logic [4:0] e_err,
                       output logic [3:0] e_ferr, output logic e_vld, output logic e_pass);
    logic [15:0] diff;
    diff   = ft ^ et;
    e_tt   = ft;
    e_err  = 5'($countones(diff));
    e_vld  = (diff != 16'h0);
    e_pass = (diff == 16'h0);
    e_ferr = 4'h0;
    for (int i = 15; i >= 0; i--) if (diff[i]) e_ferr = 4'(i);
  endtask

  // Runs one sweep and reports what was observed; comparisons are made by callers.
  task automatic do_sweep(input logic use_b, input logic [15:0] ft, input logic [15:0] et,
                          input logic extra_starts,
                          output int busy_n, output int done_n, output logic seq_ok);
    int settle;
    logic seen_done;
    logic [3:0] ev;
    settle    = use_b ? 3 : 1;
    seen_done = 1'b0;
    sel       = use_b;
    func_tt   = ft;
    exp_tt    = et;
    busy_n    = 0;
    done_n    = 0;
    seq_ok    = 1'b1;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int k = 0; k < 400 && !seen_done; k++) begin
      if (o_done) begin
        done_n++;
        seen_done = 1'b1;
        if (extra_starts) begin
          if (use_b) start_b = 1'b1; else start_a = 1'b1;
        end
        if (o_busy) busy_n++;
      end else begin
        if (o_busy) busy_n++;
        ev = 4'(k / (settle + 1));
        if (o_vec !== ev) seq_ok = 1'b0;
        if (extra_starts && k == 3 * (settle + 1)) begin
          if (use_b) start_b = 1'b1; else start_a = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    // Tail: no further busy or done, vec back at 0, results held.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (o_done) done_n++;
      if (o_busy) busy_n++;
      if (o_vec !== 4'h0) seq_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic any_set;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    exp_tt = 16'h0; func_tt = 16'h0;
    repeat (2) @(negedge clk);
    total++;
    if ({o_vec, o_busy, o_done, o_tt, o_err, o_ferr, o_fvld, o_pass} !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got vec=%h busy=%b done=%b tt=%h err=%0d fvld=%b pass=%b, want all 0",
               o_vec, o_busy, o_done, o_tt, o_err, o_fvld, o_pass);
    end
    rst_n = 1'b1;
    any_set = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if ({o_vec, o_busy, o_done, o_tt, o_err, o_ferr, o_fvld, o_pass} !== 32'h0) any_set = 1'b1;
      if ({vec_b, busy_b, done_b, tt_b, err_b, pass_b} !== 28'h0) any_set = 1'b1;
    end
    total++;
    if (any_set !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: some output became nonzero without start, want all 0");
    end
  endtask

  // Directed spec scenarios followed by random function/expected table pairs.
  task automatic test_table_sweeps();
    logic [15:0] ft [0:8];
    logic [15:0] et [0:8];
    logic [15:0] e_tt;
    logic [4:0]  e_err;
    logic [3:0]  e_ferr;
    logic        e_vld, e_pass, seq_ok;
    int          busy_n, done_n;
    ft[0] = 16'h0F0F; et[0] = 16'h0F0F;
    ft[1] = 16'h0000; et[1] = 16'h0F0F;
    ft[2] = 16'h2000; et[2] = 16'h0000;
    for (int i = 3; i < 9; i++) begin
      ft[i] = 16'($urandom);
      et[i] = (i == 3) ? ~ft[i] : ((i == 4) ? ft[i] : (ft[i] ^ 16'($urandom_range(0, 65535) & $urandom)));
    end
    for (int i = 0; i < 9; i++) begin
      model(ft[i], et[i], e_tt, e_err, e_ferr, e_vld, e_pass);
      if (i == 0) begin e_tt = 16'h0F0F; e_err = 5'd0; e_vld = 1'b0; e_pass = 1'b1; end
      if (i == 1) begin e_tt = 16'h0000; e_err = 5'd8; e_ferr = 4'h0; e_vld = 1'b1; e_pass = 1'b0; end
      if (i == 2) begin e_tt = 16'h2000; e_err = 5'd1; e_ferr = 4'hD; e_vld = 1'b1; e_pass = 1'b0; end
      do_sweep(1'b0, ft[i], et[i], 1'b0, busy_n, done_n, seq_ok);
      total++;
      if (busy_n !== 32 || done_n !== 1) begin
        bad++;
        $display("FAIL sweep%0d_timing: busy cycles=%0d dones=%0d, want 32 and 1", i, busy_n, done_n);
      end
      total++;
      if (seq_ok !== 1'b1) begin
        bad++;
        $display("FAIL sweep%0d_vec_seq: vec sequence wrong, got %b want 1", i, seq_ok);
      end
      total++;
      if (o_tt !== e_tt || o_err !== e_err || o_fvld !== e_vld || o_pass !== e_pass) begin
        bad++;
        $display("FAIL sweep%0d_results: tt=%h err=%0d fvld=%b pass=%b, want tt=%h err=%0d fvld=%b pass=%b",
                 i, o_tt, o_err, o_fvld, o_pass, e_tt, e_err, e_vld, e_pass);
      end
      if (e_vld) begin
        total++;
        if (o_ferr !== e_ferr) begin
          bad++;
          $display("FAIL sweep%0d_first_err: got %h want %h", i, o_ferr, e_ferr);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic seq_ok;
    int   busy_n, done_n;
    do_sweep(1'b0, 16'h0F0F, 16'h0F0F, 1'b1, busy_n, done_n, seq_ok);
    total++;
    if (busy_n !== 32 || done_n !== 1 || seq_ok !== 1'b1) begin
      bad++;
      $display("FAIL start_ignored_timing: busy=%0d dones=%0d seq=%b, want 32 1 1", busy_n, done_n, seq_ok);
    end
    total++;
    if (o_tt !== 16'h0F0F || o_err !== 5'd0 || o_fvld !== 1'b0 || o_pass !== 1'b1) begin
      bad++;
      $display("FAIL start_ignored_results: tt=%h err=%0d fvld=%b pass=%b, want 0f0f 0 0 1",
               o_tt, o_err, o_fvld, o_pass);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic seq_ok, saw_done;
    int   busy_n, done_n;
    sel = 1'b0; func_tt = 16'h0000; exp_tt = 16'h0F0F;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < 100 && o_vec !== 4'h7; k++) @(negedge clk);
    total++;
    if (o_vec !== 4'h7 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_reach_vec7: vec=%h busy=%b, want 7 1", o_vec, o_busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_vec, o_busy, o_done, o_tt, o_err, o_ferr, o_fvld, o_pass} !== 32'h0) begin
      bad++;
      $display("FAIL midreset_async_clear: vec=%h busy=%b tt=%h err=%0d fvld=%b, want all 0",
               o_vec, o_busy, o_tt, o_err, o_fvld);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done || o_busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_done: done/busy seen after reset, got %b want 0", saw_done);
    end
    do_sweep(1'b0, 16'h0F0F, 16'h0F0F, 1'b0, busy_n, done_n, seq_ok);
    total++;
    if (busy_n !== 32 || done_n !== 1 || seq_ok !== 1'b1 || o_tt !== 16'h0F0F || o_pass !== 1'b1 || o_err !== 5'd0) begin
      bad++;
      $display("FAIL midreset_resweep: busy=%0d dones=%0d seq=%b tt=%h err=%0d pass=%b, want 32 1 1 0f0f 0 1",
               busy_n, done_n, seq_ok, o_tt, o_err, o_pass);
    end
  endtask

  task automatic test_settle3();
    logic seq_ok;
    int   busy_n, done_n;
    do_sweep(1'b1, 16'h0F0F, 16'h0F0F, 1'b0, busy_n, done_n, seq_ok);
    total++;
    if (busy_n !== 64 || done_n !== 1) begin
      bad++;
      $display("FAIL settle3_timing: busy cycles=%0d dones=%0d, want 64 and 1", busy_n, done_n);
    end
    total++;
    if (seq_ok !== 1'b1) begin
      bad++;
      $display("FAIL settle3_vec_seq: got %b want 1", seq_ok);
    end
    total++;
    if (o_tt !== 16'h0F0F || o_err !== 5'd0 || o_fvld !== 1'b0 || o_pass !== 1'b1) begin
      bad++;
      $display("FAIL settle3_results: tt=%h err=%0d fvld=%b pass=%b, want 0f0f 0 0 1",
               o_tt, o_err, o_fvld, o_pass);
    end
    do_sweep(1'b1, 16'h0000, 16'h0F0F, 1'b0, busy_n, done_n, seq_ok);
    total++;
    if (o_tt !== 16'h0000 || o_err !== 5'd8 || o_ferr !== 4'h0 || o_fvld !== 1'b1 || o_pass !== 1'b0) begin
      bad++;
      $display("FAIL settle3_stuck0: tt=%h err=%0d ferr=%h fvld=%b pass=%b, want 0000 8 0 1 0",
               o_tt, o_err, o_ferr, o_fvld, o_pass);
    end
  endtask

  initial begin
    test_reset();
    test_table_sweeps();
    test_start_ignored();
    test_reset_mid_sweep();
    test_settle3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
